vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the VGA pixel path. Produces the pixel coordinates (vga_x, vga_y) consumed by
//  the RGB overlay stage, plus hsync/vsync, an active-video flag and frame/line strobes.
//  It is the first stage of the video pipeline and runs on the pixel clock-enable.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines)
//  SYNC_POL  0    sync polarity: 0 = active-low, 1 = active-high. Applies to hsync and vsync.
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  pix_ce       in   1   pixel clock-enable; counters advance only on clk edges where pix_ce=1
//  vga_x        out  11  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP)
//  vga_y        out  11  vertical counter, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, at SYNC_POL level
//  vsync        out  1   vertical sync, at SYNC_POL level
//  active       out  1   1 when vga_x<H_ACTIVE and vga_y<V_ACTIVE
//  line_start   out  1   one-clk strobe when vga_x enters 0
//  frame_start  out  1   one-clk strobe when (vga_x,vga_y) enters (0,0)
//  frame_cnt    out  16  frames started since reset; wraps at 0xFFFF->0
// BEHAVIOUR
//  - Single clock domain (clk). rst is synchronous and active-high. All outputs are registered and mutually
//    aligned: every output describes the current (vga_x,vga_y).
//  - Reset values (rst=1 at an edge):
//      vga_x=H_TOTAL-1 (799), vga_y=V_TOTAL-1 (524), active=0, hsync=vsync=inactive (~SYNC_POL),
//      line_start=0, frame_start=0, frame_cnt=0.
//  - First pix_ce after reset: moves to (0,0), active=1, line_start=1, frame_start=1, frame_cnt stays 0.
//    frame_cnt increments on every later entry to (0,0).
//  - On pix_ce=1: x<-x+1. When x==H_TOTAL-1, x<-0 and y<-y+1. When also y==V_TOTAL-1, y<-0.
//  - On pix_ce=0: all counters and levels hold. Strobes go to 0.
//  - Per-axis region decode, horizontal:
//      ACTIVE [0,H_ACTIVE) -> FP -> SYNC [H_ACTIVE+H_FP, +H_SYNC) -> BP -> wrap.
//    Vertical uses the same decode with the V_* parameters, in lines.
//  - hsync asserted iff x is in the H SYNC range (656..751 at defaults).
//    vsync asserted iff y is in the V SYNC range (490..491), for all x on those lines.
//  - Strobe width: line_start and frame_start are exactly one clk wide, even when pix_ce is sparse.
//  - Reset mid-frame: the next edge forces the reset values. Nothing survives from the previous frame.
//  - Width rule: H_TOTAL and V_TOTAL must each be <=2048.
//    Elaboration-time check: $error if either is exceeded or if any parameter is 0.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//      640x480@60 default constants; derived H_TOTAL/V_TOTAL and sync start/end localparams;
//      COORD_W=11; and an axis-region enum {RGN_ACTIVE, RGN_FP, RGN_SYNC, RGN_BP}.
//  - One sub-module, vga_axis_counter, parameterised by ACTIVE/FP/SYNC/BP.
//      Inputs: clk, rst, inc. Outputs: cnt, wrap (at last count), region.
//      Instantiated twice: horizontal with inc=pix_ce, vertical with inc=pix_ce & h.wrap.
//  - Top level registers sync polarity, active, strobes and frame_cnt.
// TESTING
//  1 Reset: rst=1 for 3 clks -> vga_x=799, vga_y=524, hsync=vsync=1, active=0, strobes=0, frame_cnt=0.
//  2 pix_ce=1 continuous after reset:
//      first edge -> (0,0), active=1, frame_start=1, line_start=1;
//      active=1 at x=639, 0 at x=640; hsync low exactly for x=656..751 (96 clks).
//  3 Line wrap: x=799 -> x=0, y+1, line_start one clk, frame_start=0; 800 clks between line_start pulses.
//  4 Frame: vsync low for y=490..491 (1600 pix_ce); (799,524) -> (0,0) with frame_cnt 0->1, frame_start=1;
//      period 420000 pix_ce.
//  5 pix_ce=1 every 2nd clk: counters advance once per 2 clks; frame_start and line_start are each 1 clk wide.
//  6 rst=1 for one clk at (300,200): next clk shows reset values;
//      release with pix_ce=1 -> (0,0), frame_start=1, frame_cnt=0.
//      Repeat with SYNC_POL=1: hsync/vsync idle 0 and pulse 1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants, region enum and region decode for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel rate.
package vga_timing_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef enum logic [1:0] {
    RGN_ACTIVE,
    RGN_FP,
    RGN_SYNC,
    RGN_BP
  } axis_rgn_e;

  // Regions are laid out ACTIVE, FP, SYNC, BP from count 0 upwards.
  function automatic axis_rgn_e decode_region(input logic [COORD_W-1:0] c,
                                              input int active,
                                              input int fp,
                                              input int sync);
    int v;
    v = {{(32-COORD_W){1'b0}}, c};
    if (v < active)                   return RGN_ACTIVE;
    else if (v < active + fp)         return RGN_FP;
    else if (v < active + fp + sync)  return RGN_SYNC;
    else                              return RGN_BP;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter plus region decode of the count it is about to load,
// so the parent can register region-derived levels in step with the count itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output axis_rgn_e          region
);

  localparam int                 TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [COORD_W-1:0] LAST  = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] r_cnt;
  logic [COORD_W-1:0] w_cnt_nxt;
  logic               w_wrap;

  assign w_wrap = (r_cnt == LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (inc) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= LAST;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cnt    = r_cnt;
  assign wrap   = w_wrap;
  assign region = decode_region(w_cnt_nxt, ACTIVE, FP, SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, sync levels, active flag, line/frame strobes
// and a frame counter, all registered and describing the same (vga_x, vga_y).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_params
    $error("vga_timing_gen: timing parameters must be non-zero with totals <= 2048");
  end

  logic [COORD_W-1:0] w_h_cnt, w_v_cnt;
  logic               w_h_wrap, w_v_wrap;
  axis_rgn_e          w_h_rgn, w_v_rgn;
  logic               w_v_inc;
  logic               w_enter_line, w_enter_frame;

  assign w_v_inc       = pix_ce & w_h_wrap;
  assign w_enter_line  = pix_ce & w_h_wrap;
  assign w_enter_frame = w_enter_line & w_v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (pix_ce),
    .cnt    (w_h_cnt),
    .wrap   (w_h_wrap),
    .region (w_h_rgn)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_v_inc),
    .cnt    (w_v_cnt),
    .wrap   (w_v_wrap),
    .region (w_v_rgn)
  );

  logic        r_hsync, r_vsync, r_active;
  logic        r_line_start, r_frame_start;
  logic [15:0] r_frame_cnt;
  logic        r_first_frame;

  // Regions are decoded from the counts being loaded this edge, so levels land with the new count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
      r_first_frame <= 1'b1;
    end else begin
      r_hsync       <= (w_h_rgn == RGN_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_v_rgn == RGN_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_active      <= (w_h_rgn == RGN_ACTIVE) && (w_v_rgn == RGN_ACTIVE);
      r_line_start  <= w_enter_line;
      r_frame_start <= w_enter_frame;
      // The entry to (0,0) straight out of reset starts frame 0 and is not counted.
      if (w_enter_frame) begin
        r_first_frame <= 1'b0;
        if (!r_first_frame) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  assign vga_x       = w_h_cnt;
  assign vga_y       = w_v_cnt;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule
